// File: rtl/reg8_file.sv
// reg8_file: eight-entry register file with one synchronous write port and
// one combinational read port.
//
// Ports:
//   clk   in   1       rising-edge clock for all state changes
//   clr   in   1       synchronous active-high clear of every register
//   en    in   1       write enable
//   wsel  in   SEL_W   write register index
//   rsel  in   SEL_W   read register index
//   d     in   DATA_W  write data
//   q     out  DATA_W  contents of register rsel, zero latency
module reg8_file #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned SEL_W  = 3,
  parameter int unsigned NREG   = 2 ** SEL_W
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              en,
  input  logic [SEL_W-1:0]  wsel,
  input  logic [SEL_W-1:0]  rsel,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] regs_d [NREG];

  // Clear takes priority over a write issued in the same cycle.
  always_comb begin
    for (int unsigned i = 0; i < NREG; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (clr) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        regs_d[i] = '0;
      end
    end else if (en) begin
      regs_d[wsel] = d;
    end
  end

  // No reset term here: contents are undefined until the first clr edge.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NREG; i++) begin
      regs_q[i] <= regs_d[i];
    end
  end

  // Read straight from storage; no write-data bypass.
  assign q = regs_q[rsel];

endmodule

// File: tb/tb_reg8_file.sv
// tb_reg8_file: self-checking bench for reg8_file. A plain array model holds
// the expected register contents and is updated once per rising edge from the
// inputs applied for that edge.
module tb_reg8_file;

  logic       clk;
  logic       clr;
  logic       en;
  logic [2:0] wsel;
  logic [2:0] rsel;
  logic [7:0] d;
  logic [7:0] q;

  int n_checks;
  int n_fail;
  logic [7:0] mdl [8];

  reg8_file #(
    .DATA_W(8),
    .SEL_W (3),
    .NREG  (8)
  ) dut (
    .clk (clk),
    .clr (clr),
    .en  (en),
    .wsel(wsel),
    .rsel(rsel),
    .d   (d),
    .q   (q)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit expired, got no end of test, required end of test");
    $fatal(1, "watchdog");
  end

  // One rising edge: update the model from the current inputs, then settle.
  task automatic step();
    @(posedge clk);
    if (clr) begin
      for (int i = 0; i < 8; i++) mdl[i] = 8'h00;
    end else if (en) begin
      mdl[wsel] = d;
    end
    #1;
  endtask

  task automatic test_reset();
    clr = 1'b1; en = 1'b0; wsel = 3'd0; d = 8'h00; rsel = 3'd0;
    step();
    clr = 1'b0;
    for (int i = 0; i < 8; i++) begin
      rsel = 3'(i);
      #1;
      n_checks++;
      if (q !== 8'h00) begin
        n_fail++;
        $display("FAIL reset r%0d: got %h, required 00", i, q);
      end
    end
  endtask

  task automatic test_write_readback();
    en = 1'b1; wsel = 3'd1; d = 8'hFF;
    step();
    wsel = 3'd7; d = 8'h02;
    step();
    en = 1'b0;
    for (int i = 0; i < 8; i++) begin
      logic [7:0] exp;
      exp = (i == 1) ? 8'hFF : (i == 7) ? 8'h02 : 8'h00;
      rsel = 3'(i);
      #1;
      n_checks++;
      if (q !== exp) begin
        n_fail++;
        $display("FAIL readback r%0d: got %h, required %h", i, q, exp);
      end
    end
  endtask

  task automatic test_write_disabled();
    en = 1'b0; wsel = 3'd3; d = 8'hA5;
    repeat (3) step();
    rsel = 3'd3; #1;
    n_checks++;
    if (q !== 8'h00) begin n_fail++; $display("FAIL disabled r3: got %h, required 00", q); end
    rsel = 3'd1; #1;
    n_checks++;
    if (q !== 8'hFF) begin n_fail++; $display("FAIL disabled r1: got %h, required FF", q); end
    rsel = 3'd7; #1;
    n_checks++;
    if (q !== 8'h02) begin n_fail++; $display("FAIL disabled r7: got %h, required 02", q); end
  endtask

  task automatic test_clear_timing();
    rsel = 3'd1; en = 1'b0;
    clr = 1'b1;
    #2;
    n_checks++;
    if (q !== 8'hFF) begin n_fail++; $display("FAIL clr_before_edge r1: got %h, required FF", q); end
    step();
    clr = 1'b0;
    n_checks++;
    if (q !== 8'h00) begin n_fail++; $display("FAIL clr_after_edge r1: got %h, required 00", q); end
    rsel = 3'd7; #1;
    n_checks++;
    if (q !== 8'h00) begin n_fail++; $display("FAIL clr_after_edge r7: got %h, required 00", q); end
  endtask

  task automatic test_clear_beats_write();
    en = 1'b1; wsel = 3'd2; d = 8'h33;
    step();
    clr = 1'b1; d = 8'h5A;
    step();
    clr = 1'b0; en = 1'b0;
    rsel = 3'd2; #1;
    n_checks++;
    if (q !== 8'h00) begin n_fail++; $display("FAIL clr_beats_write r2: got %h, required 00", q); end
  endtask

  task automatic test_read_during_write();
    rsel = 3'd4; en = 1'b1; wsel = 3'd4; d = 8'h11;
    step();
    d = 8'h22;
    #1;
    n_checks++;
    if (q !== 8'h11) begin n_fail++; $display("FAIL rdw_before_edge: got %h, required 11", q); end
    step();
    n_checks++;
    if (q !== 8'h22) begin n_fail++; $display("FAIL rdw_after_edge: got %h, required 22", q); end
    d = 8'h33;
    step();
    n_checks++;
    if (q !== 8'h33) begin n_fail++; $display("FAIL b2b_first: got %h, required 33", q); end
    d = 8'h44;
    step();
    en = 1'b0;
    n_checks++;
    if (q !== 8'h44) begin n_fail++; $display("FAIL b2b_final: got %h, required 44", q); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      clr  = ($urandom_range(0, 19) == 0);
      en   = $urandom_range(0, 1) != 0;
      wsel = 3'($urandom_range(0, 7));
      d    = 8'($urandom);
      rsel = 3'($urandom_range(0, 7));
      #1;
      n_checks++;
      if (q !== mdl[rsel]) begin
        n_fail++;
        $display("FAIL random_pre c%0d r%0d: got %h, required %h", c, rsel, q, mdl[rsel]);
      end
      step();
      n_checks++;
      if (q !== mdl[rsel]) begin
        n_fail++;
        $display("FAIL random_post c%0d r%0d: got %h, required %h", c, rsel, q, mdl[rsel]);
      end
    end
    clr = 1'b0; en = 1'b0;
    for (int i = 0; i < 8; i++) begin
      rsel = 3'(i);
      #1;
      n_checks++;
      if (q !== mdl[i]) begin
        n_fail++;
        $display("FAIL random_sweep r%0d: got %h, required %h", i, q, mdl[i]);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    clr = 1'b0; en = 1'b0; wsel = 3'd0; rsel = 3'd0; d = 8'h00;
    for (int i = 0; i < 8; i++) mdl[i] = 8'h00;
    @(negedge clk);
    test_reset();
    test_write_readback();
    test_write_disabled();
    test_clear_timing();
    test_clear_beats_write();
    test_read_during_write();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/reg8_file.md
Name: reg8_file

Overview:
- Register file of eight 8-bit general-purpose registers.
- One synchronous write port and one combinational (asynchronous) read port.
- Used as a small storage block in datapath experiments; one register is written per clock and any register can be read at any time.

Parameters:
- DATA_W, 8, width of each register and of d/q.
- NREG, 8, number of registers.
- SEL_W, 3, width of wsel/rsel; NREG = 2**SEL_W.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- clr  input  1  synchronous active-high clear of all registers.
- en  input  1  write enable.
- wsel  input  3  write register index, 0..7.
- rsel  input  3  read register index, 0..7.
- d  input  8  write data.
- q  output  8  read data, contents of register rsel.

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high on clr. Sampled only at the rising edge of clk; no asynchronous path.
- Storage: r0..r7, each DATA_W bits.
  - All registers are ordinary storage; r0 is not hardwired to zero.
  - Power-up contents are undefined until the first clr edge.
- Clear: at a rising edge with clr=1, every register is set to 8'h00.
  - clr has priority over en; a write requested in the same cycle is discarded.
  - Multi-cycle clr keeps all registers at 0.
- Write: at a rising edge with clr=0 and en=1, r[wsel] <= d. All other registers hold.
- Hold: at a rising edge with clr=0 and en=0, all registers hold, regardless of wsel and d.
- Read: q = r[rsel], purely combinational with zero latency.
  - A change on rsel updates q in the same delta, with no clock needed.
- Read-during-write, same index: before the edge, q shows the old value. After the edge, q shows the new value in the same cycle the register updates. No write-data bypass.
- Clear visibility: q reads 0 starting immediately after the clearing edge. Before that edge, q still shows the stored value even while clr=1.
- Index range: wsel and rsel are full-range (3 bits, 8 registers), so no out-of-range case exists.
- X/unknown select behaviour is not specified.
- Back-to-back writes: a new write every cycle is supported, to the same or different registers. The last write to a register wins.

Test Plan:
- Clear then read: clr=1 across one rising edge, then clr=0, en=0 -> q=8'h00 for rsel=0..7.
- Write/readback: en=1, wsel=1, d=8'hFF for one edge; then wsel=7, d=8'h02 for one edge; then en=0 -> rsel=1 gives q=8'hFF, rsel=7 gives q=8'h02 with no clock edge between rsel changes. Other registers read 0.
- Write disabled: en=0, wsel=3, d=8'hA5 across several edges -> r3 stays 8'h00; r1=FF and r7=02 are unchanged.
- Synchronous clear timing: with r1=8'hFF, raise clr between edges with rsel=1 -> q stays 8'hFF until the next rising edge, then becomes 8'h00. After that, rsel=7 gives 8'h00.
- Clear beats write: clr=1, en=1, wsel=2, d=8'h5A on one edge -> r2 reads 8'h00.
- Read-during-write: rsel=4, r4=8'h11; set en=1, wsel=4, d=8'h22 -> q=8'h11 before the edge and 8'h22 right after. Consecutive writes 8'h33 then 8'h44 to r4 -> final q=8'h44.
